metro_stop_scheduler: RTL
=========================

# metro_stop_scheduler

Sequences the metro train along a 6-station line: owns current station, direction, door and motion state, and latches passenger stop requests. It replaces ad-hoc LED shifting as the single source of train position; its one-hot station output drives the station LEDs and its station index drives the scrolling name display. All timing derives from an internal tick prescaler on the board clock.

## Interface
- `N_STATIONS`, default 6: number of stations; index 0 = left end, N-1 = right end.
- `TICK_DIV`, default 50_000_000: clk cycles per tick (0.5 s at 100 MHz).
- `DWELL_TICKS`, default 4: ticks the doors stay open per stop.
- `TRAVEL_TICKS`, default 8: ticks to travel between adjacent stations.
- `clk  in  1`: board clock, the only clock.
- `rst  in  1`: asynchronous, active-high reset.
- `req  in  N_STATIONS`: stop-request pulses, one bit per station.
- `hold  in  1`: level; freezes the travel countdown, doors stay closed.
- `load  in  1`: one-cycle pulse; places train at `load_station`.
- `load_station  in  3`: target index for `load`.
- `load_dir  in  1`: direction for `load` (0 = RIGHT/increasing, 1 = LEFT).
- `station_onehot  out  N_STATIONS`: LED vector, exactly one bit set.
- `station_idx  out  3`: current station index.
- `dir  out  1`: current direction.
- `door_open  out  1`: high in DWELL.
- `moving  out  1`: high in TRAVEL.
- `pending  out  N_STATIONS`: latched, unserved requests.

## Operation
- Reset values: state IDLE, station_idx 0, station_onehot 6'b000001, dir 0, door_open 0, moving 0, pending 0, tick prescaler 0.
- Tick: prescaler counts 0..TICK_DIV-1; one-cycle `tick` on wrap. Prescaler is free-running; `load` does not reset it. All dwell and travel counters advance only on `tick`.
- pending: `pending[i]` sets on `req[i]`; clears on the cycle the FSM enters DWELL at station i. Set and clear in the same cycle: clear wins. `req` for the current station while in DWELL is dropped.
- States:
  - IDLE: with nothing to serve, stay. If a service condition exists (see Configuration), go to DWELL when the current station is pending, else go to TRAVEL.
  - DWELL: door_open=1. Count DWELL_TICKS ticks, then select direction and go to TRAVEL, or go to IDLE when nothing is to be served.
  - TRAVEL: moving=1. Count TRAVEL_TICKS ticks; `hold` freezes the count. On expiry, station steps by ±1. Then go to DWELL if the new station is a stop, else restart TRAVEL.
- Direction select, on leaving DWELL/IDLE: forced 0 at station 0 and forced 1 at station N-1. Otherwise keep the current direction if any stop lies ahead, else reverse.
- `load`: synchronous, priority over all FSM activity. Takes effect only if `load_station` < N_STATIONS; out-of-range values are ignored. Sets station and dir, clears that station's pending bit, enters DWELL with the dwell counter restarted.
- Station never leaves 0..N-1; onehot always equals 1 << station_idx.

## Timing
- req to pending: 1 cycle.
- Tick to state change: the counter expires on the DWELL_TICKS-th or TRAVEL_TICKS-th tick; the state and outputs update on the next clk edge.
- Outputs are registered; station_onehot, station_idx, door_open and moving change on the same edge.
- rst asserted mid-TRAVEL: immediate return to reset values; no partial step.
- hold during DWELL: no effect; the dwell count continues.

## Configuration
- `METRO_SKIP_STOP_EN` defined:
  - Train stops only at pending stations and uses SCAN scheduling.
  - IDLE is entered when pending==0; IDLE is left when pending!=0.
  - Intermediate stations are passed without DWELL.
- Undefined:
  - Train shuttles end to end continuously and stops at every station.
  - Leaves IDLE on the first tick after reset into DWELL at station 0.
  - pending is still latched and cleared on arrival, as an indicator only.

## Structure
- Package `metro_pkg`: state enum (IDLE, DWELL, TRAVEL), constants RIGHT=0 and LEFT=1, default N_STATIONS.
- Sub-module `metro_tick_gen`: parameterised prescaler producing `tick`.

## Test plan
All tests use TICK_DIV=2, DWELL_TICKS=2, TRAVEL_TICKS=3.
- Reset, no macro: after the first tick, DWELL at 0 with door_open=1 for 2 ticks. Then TRAVEL for 3 ticks to station 1 (onehot 6'b000010), and so on. At 5, dir flips to 1.
- Macro on, idle at 0, pulse req[3]: pending=6'b001000 after 1 cycle. Train passes 1 and 2 without DWELL, DWELLs at 3, pending returns to 0, then IDLE.
- Macro on, at station 2 heading RIGHT, req[4] and req[0]: serves 4 first, reverses, then serves 0.
- hold asserted for 10 ticks mid-TRAVEL: station unchanged and moving=1 throughout. Arrival occurs 3 ticks total of non-held travel.
- load with load_station=5, load_dir=0 during TRAVEL: next cycle station_idx=5 and DWELL. On exit, dir is forced to 1.
- load_station=7: ignored. rst pulse mid-DWELL: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/metro_pkg.sv
// Shared types and constants for the metro stop scheduler.
package metro_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DWELL  = 2'd1,
        TRAVEL = 2'd2
    } metro_state_e;

    localparam logic RIGHT = 1'b0;
    localparam logic LEFT  = 1'b1;

    localparam int N_STATIONS_DEF = 6;

endpackage

// File: rtl/metro_tick_gen.sv
// Free-running prescaler: pulses tick for one clk cycle every TICK_DIV cycles.
module metro_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/metro_stop_scheduler.sv
// Train position/door/motion sequencer with latched stop requests.
// Build option METRO_SKIP_STOP_EN: stop only at requested stations (SCAN), else shuttle end to end.
module metro_stop_scheduler
    import metro_pkg::*;
#(
    parameter int N_STATIONS   = N_STATIONS_DEF,
    parameter int TICK_DIV     = 50_000_000,
    parameter int DWELL_TICKS  = 4,
    parameter int TRAVEL_TICKS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_STATIONS-1:0] req,
    input  logic                  hold,
    input  logic                  load,
    input  logic [2:0]            load_station,
    input  logic                  load_dir,
    output logic [N_STATIONS-1:0] station_onehot,
    output logic [2:0]            station_idx,
    output logic                  dir,
    output logic                  door_open,
    output logic                  moving,
    output logic [N_STATIONS-1:0] pending,
    output metro_state_e          state_dbg
);

    localparam int CNT_MAX = (DWELL_TICKS > TRAVEL_TICKS) ? DWELL_TICKS : TRAVEL_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    metro_state_e          state_q, state_d;
    logic [2:0]            station_q, station_d, step_station, clr_idx;
    logic                  dir_q, dir_d, clr_en, tick, load_ok;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [N_STATIONS-1:0] pend_q, pend_d, req_eff, clr_mask, stops;

    metro_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

`ifdef METRO_SKIP_STOP_EN
    assign stops = pend_q;
`else
    assign stops = '1;
`endif

    // Keep heading while a stop lies ahead; the line ends force the direction.
    function automatic logic sel_dir(input logic [2:0] st, input logic cur,
                                     input logic [N_STATIONS-1:0] stp);
        logic ahead;
        ahead = 1'b0;
        for (int i = 0; i < N_STATIONS; i++) begin
            if (cur == RIGHT && i > int'(st) && stp[i]) ahead = 1'b1;
            if (cur == LEFT  && i < int'(st) && stp[i]) ahead = 1'b1;
        end
        if (st == 3'd0)                        return RIGHT;
        else if (int'(st) == N_STATIONS - 1)   return LEFT;
        else                                   return ahead ? cur : ~cur;
    endfunction

    assign load_ok = load && (int'(load_station) < N_STATIONS);

    always_comb begin
        step_station = station_q;
        if (dir_q == LEFT) begin
            if (station_q != 3'd0) step_station = station_q - 3'd1;
        end else begin
            if (int'(station_q) < N_STATIONS - 1) step_station = station_q + 3'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        station_d = station_q;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        clr_en    = 1'b0;
        clr_idx   = station_q;
        if (load_ok) begin
            state_d   = DWELL;
            station_d = load_station;
            dir_d     = load_dir;
            cnt_d     = '0;
            clr_en    = 1'b1;
            clr_idx   = load_station;
        end else begin
            case (state_q)
                IDLE: begin
`ifdef METRO_SKIP_STOP_EN
                    if (pend_q != '0) begin
                        cnt_d = '0;
                        if (pend_q[station_q]) begin
                            state_d = DWELL;
                            clr_en  = 1'b1;
                        end else begin
                            state_d = TRAVEL;
                            dir_d   = sel_dir(station_q, dir_q, stops);
                        end
                    end
`else
                    if (tick) begin
                        state_d = DWELL;
                        cnt_d   = '0;
                        clr_en  = 1'b1;
                    end
`endif
                end
                DWELL: begin
                    if (tick) begin
                        if (cnt_q == CNT_W'(DWELL_TICKS - 1)) begin
                            cnt_d = '0;
`ifdef METRO_SKIP_STOP_EN
                            if (pend_q == '0) begin
                                state_d = IDLE;
                            end else begin
                                state_d = TRAVEL;
                                dir_d   = sel_dir(station_q, dir_q, stops);
                            end
`else
                            state_d = TRAVEL;
                            dir_d   = sel_dir(station_q, dir_q, stops);
`endif
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                TRAVEL: begin
                    if (tick && !hold) begin
                        if (cnt_q == CNT_W'(TRAVEL_TICKS - 1)) begin
                            cnt_d     = '0;
                            station_d = step_station;
                            if (stops[step_station]) begin
                                state_d = DWELL;
                                clr_en  = 1'b1;
                                clr_idx = step_station;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Entering DWELL at a station clears its request even if one arrives that cycle.
    always_comb begin
        req_eff = req;
        if (state_q == DWELL) req_eff[station_q] = 1'b0;
        clr_mask = '0;
        if (clr_en) clr_mask[clr_idx] = 1'b1;
        pend_d = (pend_q | req_eff) & ~clr_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            station_q <= 3'd0;
            dir_q     <= RIGHT;
            cnt_q     <= '0;
            pend_q    <= '0;
        end else begin
            state_q   <= state_d;
            station_q <= station_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
        end
    end

    assign station_idx    = station_q;
    assign station_onehot = {{(N_STATIONS-1){1'b0}}, 1'b1} << station_q;
    assign dir            = dir_q;
    assign door_open      = (state_q == DWELL);
    assign moving         = (state_q == TRAVEL);
    assign pending        = pend_q;
    assign state_dbg      = state_q;

endmodule
